multicycle_mainfsm: RTL and testbench

- Main control unit of the multicycle ARM core: sequences fetch/decode/execute/writeback over the shared ALU, memory port and register file.
- Hosts the Moore main FSM, the ALU decoder and the PC-source logic.
- Drives NextPC, PCS, RegW, MemW, FlagW and NoWrite into the condition logic, which gates them with CondEx.
- Supports data-processing (ADD, SUB, AND, ORR, CMP; register or immediate), LDR/STR, and B.

---
 rtl/multicycle_mainfsm.sv | 184 ++++++++++++++++++
 tb/tb_multicycle_mainfsm.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_mainfsm.sv
// Main control FSM of the multicycle ARM core. It sequences fetch, decode, execute
// and writeback, and hosts the ALU decoder and the PC-source request logic.
module multicycle_mainfsm #(
  parameter logic [3:0] PC_REG = 4'd15
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic       NextPC,
  output logic       PCS,
  output logic       RegW,
  output logic       MemW,
  output logic [1:0] FlagW,
  output logic       NoWrite,
  output logic       Retire,
  output logic       Illegal,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic       valid_st;
  logic       irwrite_s;
  logic       nextpc_s;
  logic       regw_s;
  logic       memw_s;
  logic       branch_s;
  logic       alu_op;
  logic       retire_s;
  logic       illegal_s;

  logic [3:0] cmd;
  logic [1:0] dec_ctrl;
  logic [1:0] dec_flagw;
  logic       dec_nowrite;
  logic       is_cmp;

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = FETCH;
    case (state)
      FETCH:  state_nxt = DECODE;
      DECODE: begin
        case (Op)
          2'b01:   state_nxt = MEMADR;
          2'b00:   state_nxt = Funct[5] ? EXECI : EXECR;
          2'b10:   state_nxt = BRANCH;
          default: state_nxt = FETCH;
        endcase
      end
      MEMADR: state_nxt = Funct[0] ? MEMRD : MEMWR;
      MEMRD:  state_nxt = MEMWB;
      EXECR:  state_nxt = ALUWB;
      EXECI:  state_nxt = ALUWB;
      default: state_nxt = FETCH;
    endcase
  end

  always_comb begin
    valid_st  = 1'b1;
    irwrite_s = 1'b0;
    nextpc_s  = 1'b0;
    regw_s    = 1'b0;
    memw_s    = 1'b0;
    branch_s  = 1'b0;
    alu_op    = 1'b0;
    retire_s  = 1'b0;
    illegal_s = 1'b0;
    AdrSrc    = 1'b0;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    ResultSrc = 2'b00;
    case (state)
      FETCH: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irwrite_s = 1'b1;
        nextpc_s  = 1'b1;
      end
      DECODE: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        illegal_s = (Op == 2'b11);
        retire_s  = (Op == 2'b11);
      end
      MEMADR: ALUSrcB = 2'b01;
      MEMRD:  AdrSrc  = 1'b1;
      MEMWB: begin
        ResultSrc = 2'b01;
        regw_s    = 1'b1;
        retire_s  = 1'b1;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        memw_s   = 1'b1;
        retire_s = 1'b1;
      end
      EXECR: alu_op = 1'b1;
      EXECI: begin
        ALUSrcB = 2'b01;
        alu_op  = 1'b1;
      end
      ALUWB: begin
        regw_s   = 1'b1;
        retire_s = 1'b1;
      end
      BRANCH: begin
        ALUSrcB   = 2'b01;
        ResultSrc = 2'b10;
        branch_s  = 1'b1;
        retire_s  = 1'b1;
      end
      default: valid_st = 1'b0;
    endcase
  end

  // ALU decoder: only data-processing execute states carry ALUOp
  assign cmd    = Funct[4:1];
  assign is_cmp = (cmd == 4'b1010);

  always_comb begin
    dec_ctrl    = 2'b00;
    dec_flagw   = 2'b00;
    dec_nowrite = 1'b0;
    if (alu_op) begin
      case (cmd)
        4'b0100: begin dec_ctrl = 2'b00; dec_flagw = {Funct[0], Funct[0]}; end
        4'b0010: begin dec_ctrl = 2'b01; dec_flagw = {Funct[0], Funct[0]}; end
        4'b0000: begin dec_ctrl = 2'b10; dec_flagw = {Funct[0], 1'b0}; end
        4'b1100: begin dec_ctrl = 2'b11; dec_flagw = {Funct[0], 1'b0}; end
        4'b1010: begin dec_ctrl = 2'b01; dec_flagw = 2'b11; dec_nowrite = 1'b1; end
        default: begin dec_ctrl = 2'b00; dec_flagw = 2'b00; end
      endcase
    end
  end

  assign ALUControl = dec_ctrl;
  // NoWrite stays up through ALUWB so the condition logic can still veto the CMP write
  assign NoWrite    = dec_nowrite | ((state == ALUWB) & is_cmp);
  assign ImmSrc     = valid_st ? Op : 2'b00;
  assign RegSrc     = valid_st ? {(Op == 2'b01), (Op == 2'b10)} : 2'b00;

  // Write-side requests are held off while reset is asserted
  assign IRWrite = irwrite_s & ~Reset;
  assign NextPC  = nextpc_s & ~Reset;
  assign RegW    = regw_s & ~Reset;
  assign MemW    = memw_s & ~Reset;
  assign FlagW   = Reset ? 2'b00 : dec_flagw;
  assign PCS     = (branch_s | (regw_s & (Rd == PC_REG))) & ~Reset;
  assign Retire  = retire_s & ~Reset;
  assign Illegal = illegal_s & ~Reset;
  assign State   = state;

endmodule

// File: tb/tb_multicycle_mainfsm.sv
// Directed bench for multicycle_mainfsm: walks each instruction class through its
// state sequence and checks the Moore outputs, decoder outputs and async reset.
module tb_multicycle_mainfsm;

  logic       clk;
  logic       Reset;
  logic [1:0] Op;
  logic [5:0] Funct;
  logic [3:0] Rd;
  logic       IRWrite, AdrSrc, NextPC, PCS, RegW, MemW, NoWrite, Retire, Illegal;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc, FlagW;
  logic [3:0] State;

  int vectors;
  int miscompares;

  multicycle_mainfsm #(.PC_REG(4'd15)) dut (
    .clk(clk), .Reset(Reset), .Op(Op), .Funct(Funct), .Rd(Rd),
    .IRWrite(IRWrite), .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc),
    .NextPC(NextPC), .PCS(PCS), .RegW(RegW), .MemW(MemW), .FlagW(FlagW),
    .NoWrite(NoWrite), .Retire(Retire), .Illegal(Illegal), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    Reset = 1'b1;
    Op    = 2'b00;
    Funct = 6'b000000;
    Rd    = 4'd0;

    // Reset held for three cycles
    repeat (3) begin
      step();
      chk("rst_state",   State,   4'd0);
      chk("rst_irwrite", IRWrite, 1'b0);
      chk("rst_nextpc",  NextPC,  1'b0);
      chk("rst_regw",    RegW,    1'b0);
      chk("rst_memw",    MemW,    1'b0);
      chk("rst_pcs",     PCS,     1'b0);
      chk("rst_flagw",   FlagW,   2'b00);
      chk("rst_retire",  Retire,  1'b0);
    end

    // LDR: 0,1,2,3,4
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd3;
    Reset = 1'b0;
    #1;
    chk("fetch_state",   State,     4'd0);
    chk("fetch_irwrite", IRWrite,   1'b1);
    chk("fetch_nextpc",  NextPC,    1'b1);
    chk("fetch_srcb",    ALUSrcB,   2'b10);
    chk("fetch_srca",    ALUSrcA,   2'b01);
    chk("fetch_res",     ResultSrc, 2'b10);
    step();
    chk("ldr_dec_state", State,  4'd1);
    chk("ldr_dec_imm",   ImmSrc, 2'b01);
    chk("ldr_dec_regsrc", RegSrc, 2'b10);
    chk("ldr_dec_irw",   IRWrite, 1'b0);
    step();
    chk("ldr_adr_state", State,      4'd2);
    chk("ldr_adr_srcb",  ALUSrcB,    2'b01);
    chk("ldr_adr_ctl",   ALUControl, 2'b00);
    step();
    chk("ldr_rd_state",  State,  4'd3);
    chk("ldr_rd_adrsrc", AdrSrc, 1'b1);
    chk("ldr_rd_retire", Retire, 1'b0);
    step();
    chk("ldr_wb_state",  State,     4'd4);
    chk("ldr_wb_res",    ResultSrc, 2'b01);
    chk("ldr_wb_regw",   RegW,      1'b1);
    chk("ldr_wb_retire", Retire,    1'b1);
    chk("ldr_wb_pcs",    PCS,       1'b0);
    step();
    chk("ldr_end_state", State, 4'd0);

    // STR: 0,1,2,5
    Funct = 6'b011000;
    step();
    chk("str_dec_state", State, 4'd1);
    step();
    chk("str_adr_state", State, 4'd2);
    chk("str_adr_memw",  MemW,  1'b0);
    step();
    chk("str_wr_state",  State,  4'd5);
    chk("str_wr_memw",   MemW,   1'b1);
    chk("str_wr_adrsrc", AdrSrc, 1'b1);
    chk("str_wr_regw",   RegW,   1'b0);
    chk("str_wr_retire", Retire, 1'b1);
    step();
    chk("str_end_state", State, 4'd0);
    chk("str_end_memw",  MemW,  1'b0);

    // ADDS immediate to PC
    Op = 2'b00; Funct = 6'b101001; Rd = 4'd15;
    step();
    chk("adds_dec_state", State, 4'd1);
    step();
    chk("adds_ex_state",  State,      4'd7);
    chk("adds_ex_srcb",   ALUSrcB,    2'b01);
    chk("adds_ex_ctl",    ALUControl, 2'b00);
    chk("adds_ex_flagw",  FlagW,      2'b11);
    chk("adds_ex_nowr",   NoWrite,    1'b0);
    step();
    chk("adds_wb_state",  State,  4'd8);
    chk("adds_wb_regw",   RegW,   1'b1);
    chk("adds_wb_pcs",    PCS,    1'b1);
    chk("adds_wb_flagw",  FlagW,  2'b00);
    chk("adds_wb_retire", Retire, 1'b1);
    step();
    chk("adds_end_state", State, 4'd0);

    // CMP register
    Funct = 6'b010101; Rd = 4'd0;
    step();
    step();
    chk("cmp_ex_state", State,      4'd6);
    chk("cmp_ex_srcb",  ALUSrcB,    2'b00);
    chk("cmp_ex_ctl",   ALUControl, 2'b01);
    chk("cmp_ex_flagw", FlagW,      2'b11);
    chk("cmp_ex_nowr",  NoWrite,    1'b1);
    step();
    chk("cmp_wb_state", State,   4'd8);
    chk("cmp_wb_nowr",  NoWrite, 1'b1);
    chk("cmp_wb_pcs",   PCS,     1'b0);
    step();

    // ORR without S
    Funct = 6'b011000;
    step();
    step();
    chk("orr_ex_state", State,      4'd6);
    chk("orr_ex_ctl",   ALUControl, 2'b11);
    chk("orr_ex_flagw", FlagW,      2'b00);
    chk("orr_ex_nowr",  NoWrite,    1'b0);
    step();
    chk("orr_wb_nowr",  NoWrite, 1'b0);
    step();

    // B: 0,1,9
    Op = 2'b10; Funct = 6'b100000;
    chk("b_fetch_state", State, 4'd0);
    step();
    chk("b_dec_regsrc", RegSrc, 2'b01);
    chk("b_dec_imm",    ImmSrc, 2'b10);
    step();
    chk("b_br_state",  State,     4'd9);
    chk("b_br_pcs",    PCS,       1'b1);
    chk("b_br_srcb",   ALUSrcB,   2'b01);
    chk("b_br_res",    ResultSrc, 2'b10);
    chk("b_br_regw",   RegW,      1'b0);
    chk("b_br_retire", Retire,    1'b1);
    step();
    chk("b_end_state", State, 4'd0);

    // Op=11: illegal in DECODE, then FETCH
    Op = 2'b11;
    chk("ill_fetch_ill", Illegal, 1'b0);
    step();
    chk("ill_dec_state",  State,   4'd1);
    chk("ill_dec_ill",    Illegal, 1'b1);
    chk("ill_dec_retire", Retire,  1'b1);
    step();
    chk("ill_end_state", State,   4'd0);
    chk("ill_end_ill",   Illegal, 1'b0);

    // Reset pulsed mid-LDR during MEMADR
    Op = 2'b01; Funct = 6'b011001; Rd = 4'd2;
    step();
    step();
    chk("arst_pre_state", State, 4'd2);
    #3;
    Reset = 1'b1;
    #1;
    chk("arst_state",   State,   4'd0);
    chk("arst_irwrite", IRWrite, 1'b0);
    step();
    Reset = 1'b0;
    #1;
    chk("arst_rel_state",   State,   4'd0);
    chk("arst_rel_irwrite", IRWrite, 1'b1);
    step();
    chk("arst_dec_state", State, 4'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
